blit_loop_seq: RTL

- Blitter loop sequencer: the control side that drives the outer line counter and consumes its zero flag.
- Runs the inner (pixel) loop, sequences optional A1/A2 pointer-update phases between lines, and pulses ocntena once per completed line.
- Consumes outer0 to terminate the blit.
- Sits between the GPU register-write path (count/command writes) and the blitter datapath and outer counter.

---
 rtl/blit_loop_seq_pkg.sv | 23 ++
 rtl/blit_loop_seq_if.sv | 32 +++
 rtl/blit_inner_cnt.sv | 32 +++
 rtl/blit_loop_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/blit_loop_seq_pkg.sv
// Shared definitions for the blitter loop sequencer: state encoding,
// default inner count width and the phase-detect convention.
package blit_loop_seq_pkg;

    localparam int ICW_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        INNER,
        A1UPD,
        A2UPD,
        OUTER,
        CHECK,
        DONE
    } blit_state_t;

    // A phase is the sys_clk cycle in which the strobe has just risen:
    // the registered copy is still low while the live strobe is high.
    function automatic logic phase_detect(input logic old_clk, input logic clk);
        return ~old_clk & clk;
    endfunction

endpackage

// File: rtl/blit_loop_seq_if.sv
// Command/datapath bundle between the GPU write path, the outer counter and
// the loop sequencer. The master side issues commands and observes strobes;
// the slave side is the sequencer itself.
interface blit_loop_seq_if #(
    parameter int ICW = blit_loop_seq_pkg::ICW_DEFAULT
);
    logic            countld;
    logic [31:0]     gpu_din;
    logic            go;
    logic            upda1;
    logic            upda2;
    logic            outer0;
    logic            step_ack;

    logic            inner_step;
    logic [ICW-1:0]  icount;
    logic            ocntena;
    logic            a1_upd;
    logic            a2_upd;
    logic            busy;
    logic            done;

    modport master (
        output countld, gpu_din, go, upda1, upda2, outer0, step_ack,
        input  inner_step, icount, ocntena, a1_upd, a2_upd, busy, done
    );

    modport slave (
        input  countld, gpu_din, go, upda1, upda2, outer0, step_ack,
        output inner_step, icount, ocntena, a1_upd, a2_upd, busy, done
    );
endinterface

// File: rtl/blit_inner_cnt.sv
// Inner (pixel) loop counter: reloadable down-counter with a last-step flag,
// built in the same style as the outer line counter.
module blit_inner_cnt import blit_loop_seq_pkg::*; #(
    parameter int ICW = ICW_DEFAULT
) (
    input  logic           sys_clk,
    input  logic           reset,
    input  logic           phase,
    input  logic           load,
    input  logic [ICW-1:0] load_val,
    input  logic           dec,
    output logic [ICW-1:0] count,
    output logic           last
);

    // Reload takes priority over a step; a zero reload wraps on the first step,
    // which is what gives a full 2^ICW-step line.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (phase) begin
            if (load) begin
                count <= load_val;
            end else if (dec) begin
                count <= count - {{(ICW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign last = (count == ICW'(1));

endmodule

// File: rtl/blit_loop_seq.sv
// Blitter loop sequencer: runs the pixel loop, optional A1/A2 pointer update
// phases between lines, pulses the outer counter once per line and finishes
// the blit when the outer counter reports zero.
module blit_loop_seq import blit_loop_seq_pkg::*; #(
    parameter int ICW = ICW_DEFAULT
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            clk,
    blit_loop_seq_if.slave  bus
);

    logic           old_clk;
    logic           phase;
    blit_state_t    state;
    blit_state_t    state_next;
    logic [ICW-1:0] inner_rld;
    logic           cnt_load;
    logic           cnt_dec;
    logic           cnt_last;
    logic           unused_din;

    assign unused_din = ^bus.gpu_din[31:ICW];

    // Registered copy of the phase strobe for rising-edge detection.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            old_clk <= 1'b0;
        end else begin
            old_clk <= clk;
        end
    end

    assign phase = phase_detect(old_clk, clk);

    // Inner reload register; a write mid-blit only affects the next line start.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            inner_rld <= '0;
        end else if (phase && bus.countld) begin
            inner_rld <= bus.gpu_din[ICW-1:0];
        end
    end

    blit_inner_cnt #(.ICW(ICW)) u_inner_cnt (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .phase    (phase),
        .load     (cnt_load),
        .load_val (inner_rld),
        .dec      (cnt_dec),
        .count    (bus.icount),
        .last     (cnt_last)
    );

    // State register, advancing only on a phase.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (phase) begin
            state <= state_next;
        end
    end

    // Next-state and counter control; go outside IDLE is simply not looked at.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.go) begin
                    if (bus.outer0) begin
                        state_next = DONE;
                    end else begin
                        cnt_load   = 1'b1;
                        state_next = INNER;
                    end
                end
            end
            INNER: begin
                if (bus.step_ack) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        if (bus.upda1) begin
                            state_next = A1UPD;
                        end else if (bus.upda2) begin
                            state_next = A2UPD;
                        end else begin
                            state_next = OUTER;
                        end
                    end
                end
            end
            A1UPD: begin
                state_next = bus.upda2 ? A2UPD : OUTER;
            end
            A2UPD: begin
                state_next = OUTER;
            end
            OUTER: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (bus.outer0) begin
                    state_next = DONE;
                end else begin
                    cnt_load   = 1'b1;
                    state_next = INNER;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output strobes are registered from the state being entered, so they
    // change only on a phase and are decoded from a single state value.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bus.inner_step <= 1'b0;
            bus.a1_upd     <= 1'b0;
            bus.a2_upd     <= 1'b0;
            bus.ocntena    <= 1'b0;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b0;
        end else if (phase) begin
            bus.inner_step <= (state_next == INNER);
            bus.a1_upd     <= (state_next == A1UPD);
            bus.a2_upd     <= (state_next == A2UPD);
            bus.ocntena    <= (state_next == OUTER);
            bus.done       <= (state_next == DONE);
            bus.busy       <= (state_next != IDLE);
        end
    end

endmodule
